branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-side producer of the branch feedback stream consumed by the predictor (fb_valid / fb_pc / fb_prediction / fb_outcome).
- Tracks predicted conditional branches in program order from decode until execute resolves them.
- On resolve: emits one registered feedback beat, compares prediction against outcome, and raises a redirect pulse with the stored recovery target on mispredict.

Parameters:
- ADDR_WIDTH, 32, PC / target width.
- DEPTH, 4, in-flight branch queue entries; power of 2, ≥2.
- CNT_WIDTH, 32, statistics counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- i_push_valid  in  1  decode presents a predicted conditional branch (jumps excluded).
- i_push_pc  in  ADDR_WIDTH  branch PC.
- i_push_prediction  in  1  1=TAKEN, 0=NOT_TAKEN.
- i_push_recovery_target  in  ADDR_WIDTH  PC to fetch if the prediction is wrong.
- o_push_ready  out  1  queue can accept a push.
- i_res_valid  in  1  execute resolves the oldest in-flight branch.
- i_res_outcome  in  1  actual direction, 1=TAKEN.
- i_flush  in  1  external pipeline flush (exception / older redirect).
- o_fb_valid  out  1  one-cycle feedback beat.
- o_fb_pc  out  ADDR_WIDTH  PC of the resolved branch.
- o_fb_prediction  out  1  stored prediction.
- o_fb_outcome  out  1  actual outcome.
- o_redirect_valid  out  1  one-cycle mispredict pulse.
- o_redirect_pc  out  ADDR_WIDTH  recovery target.
- o_count  out  $clog2(DEPTH)+1  current occupancy.
- o_underflow  out  1  sticky flag: resolve arrived with the queue empty.
- o_stat_branches  out  CNT_WIDTH  resolved branch count.
- o_stat_mispredicts  out  CNT_WIDTH  mispredict count.

Behaviour:
- Reset (async, rst_n=0):
  - Queue emptied; head/tail pointers, count, o_fb_*, o_redirect_*, o_underflow and stats all clear to 0.
  - o_push_ready=1.
  - Reset mid-operation discards all entries. No feedback is emitted for them.
- Storage: circular FIFO of {pc, prediction, recovery_target}. Pointers wrap modulo DEPTH.
- o_push_ready = (count < DEPTH), combinational from count only. A same-cycle resolve does not free space for that cycle's push.
- Push is accepted when i_push_valid & o_push_ready & ~i_flush & ~mispredict_now. A push while full is ignored.
- Resolve with count>0 and ~i_flush pops the head.
  - Next cycle: o_fb_valid=1 for exactly one cycle, with o_fb_pc/prediction/outcome from the popped entry.
  - Latency is 1 cycle.
- mispredict_now = resolve accepted & (head.prediction != i_res_outcome). At that edge:
  - Queue cleared to count=0; all younger entries are wrong-path.
  - Any same-cycle push is dropped.
  - Next cycle: o_redirect_valid=1 for one cycle and o_redirect_pc=head.recovery_target, alongside the o_fb_valid beat.
- Correct resolve plus accepted push in the same cycle: count unchanged, FIFO order preserved.
- Resolve with count=0: no feedback, no redirect, o_underflow←1. It holds until reset.
- i_flush=1:
  - Queue cleared next edge.
  - Same-cycle push and resolve are both ignored; no feedback, no redirect.
  - i_flush takes priority over everything.
- o_fb_* and o_redirect_pc hold their last values when the corresponding valid is 0.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- Defined:
  - o_stat_branches +1 on every o_fb_valid beat.
  - o_stat_mispredicts +1 on every o_redirect_valid beat.
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter registers; both outputs tied to 0.

Test Plan:
- Reset with rst_n=0 asserted asynchronously mid-cycle → immediately o_push_ready=1, o_count=0, o_fb_valid=0, o_redirect_valid=0, o_underflow=0.
- Push {pc=0x100, pred=1, rec=0x108}, next cycle resolve outcome=1 → one cycle later o_fb_valid=1, o_fb_pc=0x100, prediction=1, outcome=1, o_redirect_valid=0, o_count=0.
- Fill queue (DEPTH=4):
  - Push PCs 0x100/0x110/0x120/0x130 → o_push_ready=0, o_count=4.
  - 5th push 0x140 dropped.
  - Four correct resolves → feedback PCs 0x100, 0x110, 0x120, 0x130 in order; simultaneous push+resolve at count=2 keeps count=2.
- Mispredict flush:
  - Push 3 entries, head {pred=0, rec=0x200}; resolve outcome=1 with a same-cycle push → next cycle o_fb_valid=1 and o_redirect_valid=1, o_redirect_pc=0x200.
  - o_count=0; the dropped push never produces feedback.
- Resolve with empty queue → no o_fb_valid; o_underflow=1 and stays 1 across 10 further cycles until reset.
- i_flush with push+resolve at count=2 → o_count=0, no o_fb_valid, no redirect.
  - With BRANCH_RESOLVER_STATS_EN: after tests 2–4, o_stat_branches=6, o_stat_mispredicts=1.
  - Without the macro: both read 0.

Source files
------------

// File: rtl/branch_resolver.sv
// In-order tracker of predicted conditional branches from decode to execute; emits feedback and mispredict redirects.
// Optional saturating statistics counters are enabled with `define BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push_valid,
  input  logic [ADDR_WIDTH-1:0]      i_push_pc,
  input  logic                       i_push_prediction,
  input  logic [ADDR_WIDTH-1:0]      i_push_recovery_target,
  output logic                       o_push_ready,
  input  logic                       i_res_valid,
  input  logic                       i_res_outcome,
  input  logic                       i_flush,
  output logic                       o_fb_valid,
  output logic [ADDR_WIDTH-1:0]      o_fb_pc,
  output logic                       o_fb_prediction,
  output logic                       o_fb_outcome,
  output logic                       o_redirect_valid,
  output logic [ADDR_WIDTH-1:0]      o_redirect_pc,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_underflow,
  output logic [CNT_WIDTH-1:0]       o_stat_branches,
  output logic [CNT_WIDTH-1:0]       o_stat_mispredicts
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic                  pred_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] rec_mem  [DEPTH];

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  fb_valid_q, fb_valid_d;
  logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;
  logic                  fb_prediction_q, fb_prediction_d;
  logic                  fb_outcome_q, fb_outcome_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  underflow_q, underflow_d;

  logic push_fire, res_fire, mispredict_now, queue_empty;

  assign o_push_ready   = (count_q < CNT_W'(DEPTH));
  assign queue_empty    = (count_q == '0);
  assign res_fire       = i_res_valid & ~queue_empty & ~i_flush;
  assign mispredict_now = res_fire & (pred_mem[head_q] != i_res_outcome);
  assign push_fire      = i_push_valid & o_push_ready & ~i_flush & ~mispredict_now;

  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    fb_valid_d       = res_fire;
    fb_pc_d          = fb_pc_q;
    fb_prediction_d  = fb_prediction_q;
    fb_outcome_d     = fb_outcome_q;
    redirect_valid_d = mispredict_now;
    redirect_pc_d    = redirect_pc_q;
    underflow_d      = underflow_q | (i_res_valid & queue_empty & ~i_flush);

    if (res_fire) begin
      fb_pc_d         = pc_mem[head_q];
      fb_prediction_d = pred_mem[head_q];
      fb_outcome_d    = i_res_outcome;
    end
    if (mispredict_now) redirect_pc_d = rec_mem[head_q];

    // A flush or a mispredict discards every in-flight entry; younger ones are wrong-path.
    if (i_flush || mispredict_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_fire) tail_d = tail_q + PTR_W'(1);
      if (res_fire)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_fire) - CNT_W'(res_fire);
    end
  end

  // NOTE: the entry storage has no reset; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[tail_q]   <= i_push_pc;
      pred_mem[tail_q] <= i_push_prediction;
      rec_mem[tail_q]  <= i_push_recovery_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      fb_valid_q       <= 1'b0;
      fb_pc_q          <= '0;
      fb_prediction_q  <= 1'b0;
      fb_outcome_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      fb_valid_q       <= fb_valid_d;
      fb_pc_q          <= fb_pc_d;
      fb_prediction_q  <= fb_prediction_d;
      fb_outcome_q     <= fb_outcome_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  assign o_fb_valid       = fb_valid_q;
  assign o_fb_pc          = fb_pc_q;
  assign o_fb_prediction  = fb_prediction_q;
  assign o_fb_outcome     = fb_outcome_q;
  assign o_redirect_valid = redirect_valid_q;
  assign o_redirect_pc    = redirect_pc_q;
  assign o_count          = count_q;
  assign o_underflow      = underflow_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_WIDTH-1:0] stat_branches_q, stat_branches_d;
  logic [CNT_WIDTH-1:0] stat_mispredicts_q, stat_mispredicts_d;

  // Counters follow the registered beats and saturate at all-ones.
  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (fb_valid_q && !(&stat_branches_q))
      stat_branches_d = stat_branches_q + CNT_WIDTH'(1);
    if (redirect_valid_q && !(&stat_mispredicts_q))
      stat_mispredicts_d = stat_mispredicts_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign o_stat_branches    = stat_branches_q;
  assign o_stat_mispredicts = stat_mispredicts_q;
`else
  assign o_stat_branches    = '0;
  assign o_stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: stimulus pushes expected feedback beats into a scoreboard,
// a negedge monitor pops and compares every beat the DUT presents.
module tb_branch_resolver;

  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 32;
`ifdef BRANCH_RESOLVER_STATS_EN
  localparam int EXP_BRANCHES = 6;
  localparam int EXP_MISPRED  = 1;
`else
  localparam int EXP_BRANCHES = 0;
  localparam int EXP_MISPRED  = 0;
`endif

  typedef struct {
    logic [AW-1:0] pc;
    logic          pred;
    logic          outcome;
    logic          redir;
    logic [AW-1:0] redir_pc;
  } beat_t;

  logic          clk, rst_n;
  logic          i_push_valid, i_push_prediction, i_res_valid, i_res_outcome, i_flush;
  logic [AW-1:0] i_push_pc, i_push_recovery_target;
  logic          o_push_ready, o_fb_valid, o_fb_prediction, o_fb_outcome;
  logic          o_redirect_valid, o_underflow;
  logic [AW-1:0] o_fb_pc, o_redirect_pc;
  logic [$clog2(DEPTH):0] o_count;
  logic [CW-1:0] o_stat_branches, o_stat_mispredicts;

  int total = 0;
  int bad = 0;
  beat_t sb[$];

  branch_resolver #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_push_valid(i_push_valid), .i_push_pc(i_push_pc),
    .i_push_prediction(i_push_prediction), .i_push_recovery_target(i_push_recovery_target),
    .o_push_ready(o_push_ready),
    .i_res_valid(i_res_valid), .i_res_outcome(i_res_outcome), .i_flush(i_flush),
    .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
    .o_fb_outcome(o_fb_outcome),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_count(o_count), .o_underflow(o_underflow),
    .o_stat_branches(o_stat_branches), .o_stat_mispredicts(o_stat_mispredicts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every feedback beat must match the oldest expected beat.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (o_fb_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_fb: got pc 0x%0h expected no beat", o_fb_pc);
        end else begin
          e = sb.pop_front();
          check("fb_pc", 64'(o_fb_pc), 64'(e.pc));
          check("fb_prediction", 64'(o_fb_prediction), 64'(e.pred));
          check("fb_outcome", 64'(o_fb_outcome), 64'(e.outcome));
          check("redirect_valid", 64'(o_redirect_valid), 64'(e.redir));
          if (e.redir) check("redirect_pc", 64'(o_redirect_pc), 64'(e.redir_pc));
        end
      end else if (o_redirect_valid === 1'b1) begin
        total++;
        bad++;
        $display("FAIL unexpected_redirect: got pc 0x%0h expected no redirect", o_redirect_pc);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs, then release them 1 time unit after the edge.
  task automatic step(input logic pv, input logic [AW-1:0] pc, input logic pred,
                      input logic [AW-1:0] rec, input logic rv, input logic rout, input logic fl);
    i_push_valid = pv; i_push_pc = pc; i_push_prediction = pred; i_push_recovery_target = rec;
    i_res_valid = rv; i_res_outcome = rout; i_flush = fl;
    @(posedge clk);
    #1;
    i_push_valid = 1'b0; i_res_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic pred, input logic [AW-1:0] rec);
    step(1'b1, pc, pred, rec, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expect_beat(input logic [AW-1:0] pc, input logic pred, input logic outcome,
                             input logic redir, input logic [AW-1:0] rpc);
    beat_t e;
    e.pc = pc; e.pred = pred; e.outcome = outcome; e.redir = redir; e.redir_pc = rpc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_push_valid = 1'b0; i_push_pc = '0; i_push_prediction = 1'b0; i_push_recovery_target = '0;
    i_res_valid = 1'b0; i_res_outcome = 1'b0; i_flush = 1'b0;
    #1;
    check("reset_ready", 64'(o_push_ready), 64'd1);
    check("reset_count", 64'(o_count), 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single correct resolve, one cycle latency.
    push(32'h100, 1'b1, 32'h108);
    check("t2_count_after_push", 64'(o_count), 64'd1);
    expect_beat(32'h100, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("t2_fb_valid", 64'(o_fb_valid), 64'd1);
    check("t2_count", 64'(o_count), 64'd0);
    idle(1);
    check("t2_fb_hold_pc", 64'(o_fb_pc), 64'h100);

    // Fill, overflow drop, in-order drain, simultaneous push+resolve.
    push(32'h100, 1'b1, 32'h104);
    push(32'h110, 1'b0, 32'h114);
    push(32'h120, 1'b1, 32'h124);
    push(32'h130, 1'b0, 32'h134);
    check("t3_full_count", 64'(o_count), 64'd4);
    check("t3_full_ready", 64'(o_push_ready), 64'd0);
    push(32'h140, 1'b1, 32'h144);
    check("t3_drop_count", 64'(o_count), 64'd4);
    expect_beat(32'h100, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    expect_beat(32'h110, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t3_count2", 64'(o_count), 64'd2);
    expect_beat(32'h120, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 32'h150, 1'b1, 32'h154, 1'b1, 1'b1, 1'b0);
    check("t3_push_res_count", 64'(o_count), 64'd2);
    expect_beat(32'h130, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("t3_count1", 64'(o_count), 64'd1);
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t3_flush_count", 64'(o_count), 64'd0);

    // Mispredict clears the queue and drops the same-cycle push.
    push(32'h300, 1'b0, 32'h200);
    push(32'h310, 1'b1, 32'h314);
    push(32'h320, 1'b1, 32'h324);
    expect_beat(32'h300, 1'b0, 1'b1, 1'b1, 32'h200);
    step(1'b1, 32'h330, 1'b1, 32'h334, 1'b1, 1'b1, 1'b0);
    check("t4_redirect_valid", 64'(o_redirect_valid), 64'd1);
    check("t4_count", 64'(o_count), 64'd0);
    idle(3);
    check("t4_count_later", 64'(o_count), 64'd0);
    check("stat_branches", 64'(o_stat_branches), 64'(EXP_BRANCHES));
    check("stat_mispredicts", 64'(o_stat_mispredicts), 64'(EXP_MISPRED));

    // Resolve on an empty queue sets the sticky underflow flag.
    check("t5_underflow_before", 64'(o_underflow), 64'd0);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("t5_underflow_sticky", 64'(o_underflow), 64'd1);
      idle(1);
    end

    // External flush overrides push and resolve.
    push(32'h400, 1'b1, 32'h404);
    push(32'h410, 1'b0, 32'h414);
    check("t6_count2", 64'(o_count), 64'd2);
    step(1'b1, 32'h420, 1'b1, 32'h424, 1'b1, 1'b0, 1'b1);
    check("t6_flush_count", 64'(o_count), 64'd0);
    idle(2);

    // Asynchronous reset in mid-cycle discards entries and clears flags.
    push(32'h500, 1'b1, 32'h504);
    push(32'h510, 1'b0, 32'h514);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(o_push_ready), 64'd1);
    check("arst_count", 64'(o_count), 64'd0);
    check("arst_fb_valid", 64'(o_fb_valid), 64'd0);
    check("arst_redirect_valid", 64'(o_redirect_valid), 64'd0);
    check("arst_underflow", 64'(o_underflow), 64'd0);
    check("arst_stat_branches", 64'(o_stat_branches), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(3);
    check("post_reset_count", 64'(o_count), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
